exhaustive_resp_checker: RTL and testbench
==========================================

// Module: exhaustive_resp_checker
// PURPOSE
//  Response-side counterpart to our exhaustive-stimulus benches, built as synthesizable RTL.
//  Walks every N_IN-bit input pattern in ascending order and holds each one for HOLD cycles.
//  On the last hold cycle it compares the DUT response against a golden table.
//  Counts mismatches, records the first failing pattern and reports pass/fail.
//  Sits beside a combinational DUT such as top_level: stim feeds the DUT inputs, resp takes its outputs.
// PARAMETERS
//  N_IN      3       DUT input width; 2**N_IN patterns are applied
//  N_OUT     3       DUT output width
//  HOLD      10      cycles each pattern is held (>=1); resp sampled on the last one
//  EXPECTED  0       golden table, (2**N_IN)*N_OUT bits; entry i at EXPECTED[i*N_OUT +: N_OUT]
// PORTS
//  clk               in   1           single clock, rising edge
//  rst               in   1           synchronous, active-high reset
//  start             in   1           level-sampled; begins a run when in IDLE or DONE
//  stim              out  N_IN        pattern driven to the DUT (registered)
//  resp              in   N_OUT       DUT response; must settle within HOLD cycles
//  busy              out  1           high while in APPLY
//  done              out  1           high in DONE until the next start or rst
//  pass              out  1           valid when done: err_count==0
//  err_count         out  N_IN+1      mismatches this run; saturation impossible, max 2**N_IN
//  first_fail_idx    out  N_IN        index of the first mismatching pattern
//  first_fail_valid  out  1           set on the first mismatch of the run
// BEHAVIOUR
//  Reset
//   - rst=1 at any edge, including mid-run: state<=IDLE.
//   - stim, idx, hold_cnt, err_count and first_fail_idx <= 0.
//   - busy, done, pass and first_fail_valid <= 0.
//  States: IDLE, APPLY, DONE. All outputs are registered.
//  IDLE
//   - stim=0.
//   - start=1 -> APPLY with idx=0, hold_cnt=0, err_count=0, first_fail_valid=0.
//  APPLY
//   - stim=idx and busy=1.
//   - hold_cnt < HOLD-1: hold_cnt++.
//   - hold_cnt==HOLD-1 (compare edge):
//     - If resp != EXPECTED[idx]: err_count++. If first_fail_valid=0, also set it and load first_fail_idx=idx.
//     - If idx==2**N_IN-1: go to DONE.
//     - Otherwise: idx++ and hold_cnt=0, so stim changes on the same edge.
//   - start is ignored while in APPLY.
//  DONE
//   - done=1, busy=0, pass=(final err_count==0). stim holds the last pattern.
//   - start=1 restarts exactly as from IDLE: clears counters and flags; done/pass drop on that edge.
//  Timing
//   - Run length is (2**N_IN)*HOLD cycles in APPLY. done rises on the edge after the last compare.
//   - Default parameters: 80 APPLY cycles, done asserted 81 edges after the edge sampling start.
//  Width rules
//   - idx and hold_cnt are unsigned.
//   - hold_cnt width is clog2(HOLD), minimum 1.
//   - err_count cannot wrap.
//  Simultaneous events
//   - rst has priority over start.
//   - A mismatch on the final pattern is counted before DONE; pass reflects it.
// STRUCTURE
//  - Shared include chk_defs.vh holds:
//    - state localparams ST_IDLE=2'd0, ST_APPLY=2'd1, ST_DONE=2'd2;
//    - a clog2 function, shared by the hold_cnt and idx sizing.
//  - Sub-module pattern_sequencer: the idx and hold_cnt counters.
//    - Inputs: clear, enable.
//    - Outputs: idx, compare_now, last_pattern.
//  - Top level: FSM, golden compare, error bookkeeping.
// TESTING
//  1. Default params, EXPECTED=24'hFAC688, resp modelled as the golden table of stim.
//     -> done after 81 cycles; pass=1; err_count=0; first_fail_valid=0.
//  2. Same, but force resp bit0 inverted only for stim=3'd5.
//     -> err_count=1; first_fail_idx=5; pass=0.
//  3. resp forced to 3'b000, EXPECTED=24'hFAC688 (entries 0..7: 0,1,2,3,4,5,6,7).
//     -> err_count=7; first_fail_idx=1.
//  4. rst pulsed during pattern 4, hold cycle 3.
//     -> next edge: IDLE, stim=0, err_count=0, busy=0; then start -> full clean run passes.
//  5. start held high through a run, then asserted again in DONE.
//     -> no restart while busy; restart from DONE clears done the next edge; second run identical to first.
//  6. HOLD=1, N_IN=2.
//     -> stim steps 0,1,2,3 on consecutive edges; done after 4 APPLY cycles.

Source files
------------

// File: rtl/exhaustive_resp_checker_pkg.sv
// Shared definitions for the exhaustive response checker: FSM state
// encoding and the width helper used to size the pattern/hold counters.
package exhaustive_resp_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..value-1, never less than one bit so that a
  // single-cycle hold still gets a legal (constant zero) counter.
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) begin
      width++;
    end
    return width;
  endfunction

endpackage

// File: rtl/exhaustive_resp_checker_pattern_sequencer.sv
// Pattern sequencer: walks idx through every N_IN-bit value in ascending
// order, dwelling HOLD cycles on each. compare_now flags the last dwell
// cycle of the current pattern; last_pattern flags the final index.
module pattern_sequencer
  import exhaustive_resp_checker_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int HOLD = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  output logic [N_IN-1:0] idx,
  output logic            compare_now,
  output logic            last_pattern
);

  localparam int                HOLD_W    = clog2_min1(HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [N_IN-1:0]   IDX_LAST  = '1;
  localparam logic [N_IN-1:0]   IDX_ONE   = N_IN'(1);

  logic [HOLD_W-1:0] hold_cnt;

  assign last_pattern = (idx == IDX_LAST);
  assign compare_now  = enable && (hold_cnt == HOLD_LAST);

  // Dwell counter and pattern index; the index advances on the same edge
  // that closes the dwell so the next pattern appears without a gap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx      <= '0;
      hold_cnt <= '0;
    end else if (enable) begin
      if (hold_cnt == HOLD_LAST) begin
        hold_cnt <= '0;
        if (!last_pattern) begin
          idx <= idx + IDX_ONE;
        end
      end else begin
        hold_cnt <= hold_cnt + HOLD_ONE;
      end
    end
  end

endmodule

// File: rtl/exhaustive_resp_checker.sv
// Exhaustive response checker: drives every input pattern to a
// combinational DUT, compares its response against a golden table on the
// last hold cycle of each pattern, and reports mismatch count, the first
// failing pattern and an overall pass flag.
module exhaustive_resp_checker
  import exhaustive_resp_checker_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 3,
  parameter int HOLD  = 10,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  stim,
  input  logic [N_OUT-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic [N_IN-1:0]  first_fail_idx,
  output logic             first_fail_valid
);

  localparam int               N_PAT   = 2**N_IN;
  localparam int               ERR_W   = N_IN + 1;
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  state_t state_reg, state_next;

  logic seq_clear;
  logic seq_enable;
  logic compare_now;
  logic last_pattern;

  logic [N_OUT-1:0] golden_tbl [N_PAT];
  logic [N_OUT-1:0] golden;
  logic             mismatch;

  logic [ERR_W-1:0] err_count_next;
  logic [N_IN-1:0]  first_fail_idx_next;
  logic             first_fail_valid_next;
  logic             busy_next;
  logic             done_next;
  logic             pass_next;

  // The sequencer's index register is the stimulus itself, so stim is
  // registered and changes on the very edge that closes a dwell.
  pattern_sequencer #(
    .N_IN (N_IN),
    .HOLD (HOLD)
  ) u_seq (
    .clk          (clk),
    .rst          (rst),
    .clear        (seq_clear),
    .enable       (seq_enable),
    .idx          (stim),
    .compare_now  (compare_now),
    .last_pattern (last_pattern)
  );

  // Unpack the flat golden vector into one entry per pattern.
  generate
    for (genvar gi = 0; gi < N_PAT; gi++) begin : g_golden
      assign golden_tbl[gi] = EXPECTED[gi*N_OUT +: N_OUT];
    end
  endgenerate

  assign golden   = golden_tbl[stim];
  assign mismatch = (resp != golden);

  // Next-state and next-output logic; starting a run clears all bookkeeping.
  always_comb begin
    state_next            = state_reg;
    seq_clear             = 1'b0;
    seq_enable            = 1'b0;
    err_count_next        = err_count;
    first_fail_idx_next   = first_fail_idx;
    first_fail_valid_next = first_fail_valid;
    busy_next             = 1'b0;
    done_next             = 1'b0;
    pass_next             = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next            = ST_APPLY;
          seq_clear             = 1'b1;
          err_count_next        = '0;
          first_fail_idx_next   = '0;
          first_fail_valid_next = 1'b0;
          busy_next             = 1'b1;
        end
      end

      ST_APPLY: begin
        seq_enable = 1'b1;
        busy_next  = 1'b1;
        if (compare_now) begin
          if (mismatch) begin
            err_count_next = err_count + ERR_ONE;
            if (!first_fail_valid) begin
              first_fail_valid_next = 1'b1;
              first_fail_idx_next   = stim;
            end
          end
          if (last_pattern) begin
            state_next = ST_DONE;
            busy_next  = 1'b0;
          end
        end
      end

      ST_DONE: begin
        if (start) begin
          state_next            = ST_APPLY;
          seq_clear             = 1'b1;
          err_count_next        = '0;
          first_fail_idx_next   = '0;
          first_fail_valid_next = 1'b0;
          busy_next             = 1'b1;
        end else begin
          done_next = 1'b1;
          pass_next = (err_count == '0);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset wins over any start request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      err_count        <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
    end else begin
      state_reg        <= state_next;
      err_count        <= err_count_next;
      first_fail_idx   <= first_fail_idx_next;
      first_fail_valid <= first_fail_valid_next;
      busy             <= busy_next;
      done             <= done_next;
      pass             <= pass_next;
    end
  end

endmodule

// File: tb/tb_exhaustive_resp_checker.sv
// Bench for exhaustive_resp_checker: a default-sized instance driven
// through full runs with several response behaviours, plus a HOLD=1,
// N_IN=2 instance for the single-cycle dwell case.
module tb_exhaustive_resp_checker;

  localparam logic [23:0] GOLD3 = 24'hFAC688;
  localparam logic [7:0]  GOLD2 = 8'hE4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] stim;
  logic [2:0] resp;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_fail_idx;
  logic       first_fail_valid;

  logic       start2;
  logic [1:0] stim2;
  logic [1:0] resp2;
  logic       busy2;
  logic       done2;
  logic       pass2;
  logic [2:0] err_count2;
  logic [1:0] first_fail_idx2;
  logic       first_fail_valid2;

  int mode;
  int n_checks;
  int n_pass;

  typedef struct {
    int err;
    int ffi;
    bit ffv;
    bit pass;
  } exp_t;

  exp_t sb_q[$];

  exhaustive_resp_checker #(
    .N_IN     (3),
    .N_OUT    (3),
    .HOLD     (10),
    .EXPECTED (GOLD3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .stim             (stim),
    .resp             (resp),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_idx   (first_fail_idx),
    .first_fail_valid (first_fail_valid)
  );

  exhaustive_resp_checker #(
    .N_IN     (2),
    .N_OUT    (2),
    .HOLD     (1),
    .EXPECTED (GOLD2)
  ) dut2 (
    .clk              (clk),
    .rst              (rst),
    .start            (start2),
    .stim             (stim2),
    .resp             (resp2),
    .busy             (busy2),
    .done             (done2),
    .pass             (pass2),
    .err_count        (err_count2),
    .first_fail_idx   (first_fail_idx2),
    .first_fail_valid (first_fail_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] gold_of(input logic [2:0] s);
    logic [23:0] tbl;
    tbl = GOLD3;
    return tbl[s*3 +: 3];
  endfunction

  // Response model of the DUT under test: 0 = correct, 1 = bit0 wrong at
  // pattern 5, 2 = stuck at zero.
  function automatic logic [2:0] resp_of(input int m, input logic [2:0] s);
    logic [2:0] r;
    r = gold_of(s);
    if (m == 1 && s == 3'd5) r = r ^ 3'b001;
    if (m == 2) r = 3'b000;
    return r;
  endfunction

  always_comb resp  = resp_of(mode, stim);
  always_comb resp2 = stim2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic push_expected(input int m);
    exp_t e;
    e.err = 0;
    e.ffi = 0;
    e.ffv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (resp_of(m, 3'(i)) != gold_of(3'(i))) begin
        e.err++;
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ffi = i;
        end
      end
    end
    e.pass = (e.err == 0);
    sb_q.push_back(e);
  endtask

  // One full run: start is raised at a negedge and dropped once cnt
  // reaches hold_hi edges after the start edge.
  task automatic run_and_check(input int m, input int hold_hi, input string tag);
    int   cnt;
    bit   seen;
    exp_t e;
    mode  = m;
    push_expected(m);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_go_busy"}, busy, 1);
    chk({tag, "_go_done"}, done, 0);
    chk({tag, "_go_stim"}, stim, 0);
    chk({tag, "_go_err"}, err_count, 0);
    chk({tag, "_go_ffv"}, first_fail_valid, 0);
    if (hold_hi == 0) start = 1'b0;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 200) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (cnt >= hold_hi) start = 1'b0;
      if (cnt < 80 && (cnt % 10) == 0) chk({tag, "_stim"}, stim, cnt / 10);
      if (cnt == 80) chk({tag, "_busy_end"}, busy, 0);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_edge"}, cnt, 81);
    chk({tag, "_stim_hold"}, stim, 7);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_err"}, err_count, e.err);
      chk({tag, "_ffv"}, first_fail_valid, e.ffv);
      chk({tag, "_pass"}, pass, e.pass);
      if (e.ffv) chk({tag, "_ffi"}, first_fail_idx, e.ffi);
      $display("run %s: err=%0d ffv=%0d ffi=%0d pass=%0d", tag, err_count,
               first_fail_valid, first_fail_idx, pass);
    end
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_pass   = 0;
    mode     = 0;
    rst      = 1'b1;
    start    = 1'b0;
    start2   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stim", stim, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ffv", first_fail_valid, 0);
    chk("rst_ffi", first_fail_idx, 0);
    rst = 1'b0;

    run_and_check(0, 0, "t1_clean");
    run_and_check(1, 0, "t2_bit0_at5");
    run_and_check(2, 0, "t3_stuck0");

    // Reset in the middle of pattern 4, hold cycle 3.
    mode  = 2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (43) @(posedge clk);
    @(negedge clk);
    chk("t4_pre_stim", stim, 4);
    chk("t4_pre_err", err_count, 3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t4_rst_stim", stim, 0);
    chk("t4_rst_err", err_count, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_done", done, 0);
    chk("t4_rst_ffv", first_fail_valid, 0);
    $display("run t4_midrun_rst: stim=%0d err=%0d busy=%0d", stim, err_count, busy);
    run_and_check(0, 0, "t4_after_rst");

    // start held through most of a run, then a restart from DONE.
    run_and_check(1, 50, "t5_held");
    run_and_check(1, 0, "t5_restart");

    // Single-cycle dwell on the small instance.
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    chk("t6_stim0", stim2, 0);
    chk("t6_busy0", busy2, 1);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t6_stim_step", stim2, k);
      chk("t6_busy_step", busy2, 1);
    end
    @(posedge clk);
    @(negedge clk);
    chk("t6_busy_end", busy2, 0);
    cnt = 4;
    while (!done2 && cnt < 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    chk("t6_done_edge", cnt, 5);
    chk("t6_err", err_count2, 0);
    chk("t6_pass", pass2, 1);
    chk("t6_stim_hold", stim2, 3);
    $display("run t6_hold1: err=%0d pass=%0d done_edge=%0d", err_count2, pass2, cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
